// File: rtl/fc_input_layer.sv
// fc_input_layer: pops LAYER_HEIGHT words from a first-word-fall-through FIFO and presents them as one vector.
// Define FC_INPUT_DOUBLE_BUFFER_EN for two ping-pong banks that keep collecting while a vector is held.
module fc_input_layer #(
  parameter int WORD_SIZE    = 8,
  parameter int LAYER_HEIGHT = 10
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   empty_i,
  input  logic [WORD_SIZE-1:0]                   data_i,
  output logic                                   ren_o,
  output logic                                   valid_o,
  input  logic                                   ready_i,
  output logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_o
);

  localparam int CNT_W = (LAYER_HEIGHT > 1) ? $clog2(LAYER_HEIGHT) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(LAYER_HEIGHT - 1);

  typedef enum logic {
    S_COLLECT,
    S_HOLD
  } state_t;

  logic [CNT_W-1:0] r_cnt;
  logic             w_ren;
  logic             w_last;
  logic             w_xfer;

  assign w_last = (r_cnt == LAST_SLOT);

`ifdef FC_INPUT_DOUBLE_BUFFER_EN

  // r_wr is the bank being filled, r_rd the bank presented; they coincide when both are empty or both are full.
  state_t                                         r_state [2];
  logic [1:0][LAYER_HEIGHT-1:0][WORD_SIZE-1:0]    r_bank;
  logic                                           r_wr;
  logic                                           r_rd;

  assign w_ren  = reset_i & ~empty_i & (r_state[r_wr] == S_COLLECT);
  assign w_xfer = (r_state[r_rd] == S_HOLD) & ready_i;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state[0] <= S_COLLECT;
      r_state[1] <= S_COLLECT;
      r_bank     <= '0;
      r_cnt      <= '0;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
    end else begin
      if (w_ren) begin
        for (int k = 0; k < LAYER_HEIGHT; k++) begin
          if (r_cnt == CNT_W'(k)) begin
            r_bank[r_wr][k] <= data_i;
          end
        end
        if (w_last) begin
          r_cnt          <= '0;
          r_state[r_wr]  <= S_HOLD;
          r_wr           <= ~r_wr;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      // A capture and a transfer on the same edge always touch different banks.
      if (w_xfer) begin
        r_state[r_rd] <= S_COLLECT;
        r_rd          <= ~r_rd;
      end
    end
  end

  assign valid_o = (r_state[r_rd] == S_HOLD);
  assign data_o  = r_bank[r_rd];

`else

  state_t                                 r_state;
  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] r_bank;

  assign w_ren  = reset_i & ~empty_i & (r_state == S_COLLECT);
  assign w_xfer = (r_state == S_HOLD) & ready_i;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state <= S_COLLECT;
      r_bank  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_ren) begin
            for (int k = 0; k < LAYER_HEIGHT; k++) begin
              if (r_cnt == CNT_W'(k)) begin
                r_bank[k] <= data_i;
              end
            end
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= S_HOLD;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_xfer) begin
            r_state <= S_COLLECT;
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  assign valid_o = (r_state == S_HOLD);
  assign data_o  = r_bank;

`endif

  assign ren_o = w_ren;

endmodule

// File: tb/tb_fc_input_layer.sv
// Self-checking bench for fc_input_layer: a FIFO model feeds words, a scoreboard checks each transferred vector.
// Double-buffer-only timing checks are enabled when FC_INPUT_DOUBLE_BUFFER_EN is defined.
module tb_fc_input_layer;

  localparam int WS = 8;
  localparam int LH = 10;
  localparam int VW = WS * LH;
  typedef logic [VW-1:0] vec_t;

  typedef struct {
    vec_t vec;
    bit   bubbles;
    vec_t expVec;
  } vec_rec_t;

  logic                  clk_i = 1'b0;
  logic                  reset_i;
  logic                  empty_i;
  logic [WS-1:0]         data_i;
  logic                  ren_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [LH-1:0][WS-1:0] data_o;

  logic [WS-1:0] fifoQ[$];
  vec_t          expQ[$];
  int            riseQ[$];
  vec_rec_t      recs[4];
  int            cycle = 0;
  int            lastPopCycle = 0;
  int            popCount = 0;
  bit            bubbleEn = 1'b0;
  bit            prevValid = 1'b0;
  int            checkCount = 0;
  int            passCount = 0;

  fc_input_layer #(.WORD_SIZE(WS), .LAYER_HEIGHT(LH)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .empty_i (empty_i),
    .data_i  (data_i),
    .ren_o   (ren_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input vec_t actual, input vec_t expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input vec_rec_t rec);
    for (int k = 0; k < LH; k++) fifoQ.push_back(rec.vec[k*WS +: WS]);
    expQ.push_back(rec.expVec);
    bubbleEn = rec.bubbles;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!valid_o && n < 300) begin
      tick();
      n++;
    end
    checkOutput(name, vec_t'(valid_o), vec_t'(1));
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    checkOutput(name, vec_t'(expQ.size()), '0);
  endtask

  // FIFO model: pops on edges where ren_o was high, then presents the new head a little after the edge.
  always @(posedge clk_i) begin
    cycle++;
    if (ren_o) begin
      checkOutput("popWhileEmpty", vec_t'(empty_i), '0);
      if (fifoQ.size() > 0) void'(fifoQ.pop_front());
      popCount++;
      lastPopCycle = cycle;
    end
    #2;
    empty_i = (fifoQ.size() == 0) || (bubbleEn && ($urandom_range(0, 1) == 1));
    data_i  = (fifoQ.size() > 0) ? fifoQ[0] : '0;
  end

  // Scoreboard: a transfer happens on the next edge whenever valid_o & ready_i hold at the falling edge.
  always @(negedge clk_i) begin
    if (valid_o && !prevValid) riseQ.push_back(cycle);
    prevValid = valid_o;
    if (reset_i && valid_o && ready_i) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpectedVector: got %h, expected none", data_o);
      end else begin
        checkOutput("scoreboard", vec_t'(data_o), expQ.pop_front());
      end
    end
  end

  initial begin
    int base;
    int n;
    vec_rec_t a, b, c;

    reset_i = 1'b0;
    ready_i = 1'b0;
    empty_i = 1'b1;
    data_i  = '0;

    recs[0] = '{vec: 80'h01_00_05_09_02_03_05_01_00_01, bubbles: 1'b0, expVec: 80'h01_00_05_09_02_03_05_01_00_01};
    recs[1] = '{vec: 80'h06_08_0f_0f_02_01_01_03_03_04, bubbles: 1'b0, expVec: 80'h06_08_0f_0f_02_01_01_03_03_04};
    recs[2] = '{vec: 80'hde_ad_be_ef_00_11_22_33_44_55, bubbles: 1'b1, expVec: 80'hde_ad_be_ef_00_11_22_33_44_55};
    recs[3] = '{vec: 80'hff_00_ff_00_80_7f_01_fe_c3_3c, bubbles: 1'b1, expVec: 80'hff_00_ff_00_80_7f_01_fe_c3_3c};

    repeat (3) tick();
    $display("[TB] reset checks");
    applyStimulus(recs[0]);
    tick();
    checkOutput("resetRen", vec_t'(ren_o), '0);
    checkOutput("resetValid", vec_t'(valid_o), '0);
    checkOutput("resetData", vec_t'(data_o), '0);
    ready_i = 1'b1;
    reset_i = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < 4; i++) begin
      if (i > 0) applyStimulus(recs[i]);
      waitValid("tableValid");
      checkOutput("validAfterLastPop", vec_t'(lastPopCycle), vec_t'(cycle));
      waitDrain("tableDrain");
      checkOutput("validOneCycle", vec_t'(valid_o), '0);
      bubbleEn = 1'b0;
    end

    $display("[TB] back-to-back");
    riseQ.delete();
    applyStimulus(recs[0]);
    applyStimulus(recs[1]);
    waitDrain("b2bDrain");
    checkOutput("b2bRiseCount", vec_t'(riseQ.size()), vec_t'(2));
    if (riseQ.size() >= 2) begin
`ifdef FC_INPUT_DOUBLE_BUFFER_EN
      checkOutput("b2bSpacing", vec_t'(riseQ[1] - riseQ[0]), vec_t'(LH));
`else
      checkOutput("b2bSpacing", vec_t'(riseQ[1] - riseQ[0]), vec_t'(LH + 1));
`endif
    end

    $display("[TB] backpressure");
    ready_i = 1'b0;
    applyStimulus(recs[2]);
    applyStimulus(recs[3]);
    bubbleEn = 1'b0;
    waitValid("bpValid");
    for (int k = 0; k < 20; k++) begin
      tick();
      checkOutput("bpValidHeld", vec_t'(valid_o), vec_t'(1));
      checkOutput("bpDataHeld", vec_t'(data_o), recs[2].expVec);
`ifndef FC_INPUT_DOUBLE_BUFFER_EN
      checkOutput("bpRenLow", vec_t'(ren_o), '0);
`endif
    end
    ready_i = 1'b1;
    tick();
`ifndef FC_INPUT_DOUBLE_BUFFER_EN
    checkOutput("bpTransferEdge", vec_t'(valid_o), '0);
`endif
    waitDrain("bpDrain");

    $display("[TB] reset mid-collection");
    base = popCount;
    applyStimulus(recs[1]);
    n = 0;
    while (popCount < base + 4 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("popsBeforeReset", vec_t'(popCount - base), vec_t'(4));
    reset_i = 1'b0;
    fifoQ.delete();
    void'(expQ.pop_back());
    tick();
    reset_i = 1'b1;
    checkOutput("midResetValid", vec_t'(valid_o), '0);
    checkOutput("midResetData", vec_t'(data_o), '0);
    applyStimulus(recs[0]);
    waitValid("postResetValid");
    waitDrain("postResetDrain");

`ifdef FC_INPUT_DOUBLE_BUFFER_EN
    $display("[TB] ping-pong stall");
    a = recs[0];
    b = recs[1];
    c = recs[2];
    c.bubbles = 1'b0;
    ready_i = 1'b0;
    base = popCount;
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(c);
    n = 0;
    while (popCount < base + 2*LH && n < 100) begin
      tick();
      n++;
    end
    tick();
    tick();
    checkOutput("ppPops", vec_t'(popCount - base), vec_t'(2*LH));
    checkOutput("ppRenStall", vec_t'(ren_o), '0);
    checkOutput("ppValid", vec_t'(valid_o), vec_t'(1));
    checkOutput("ppFirstData", vec_t'(data_o), a.expVec);
    ready_i = 1'b1;
    tick();
    checkOutput("ppValidContinuous", vec_t'(valid_o), vec_t'(1));
    checkOutput("ppSecondData", vec_t'(data_o), b.expVec);
    waitDrain("ppDrain");
`else
    a = recs[0];
    b = recs[1];
    c = recs[2];
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
